// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - two-stage valid/ready shifter (SLL/SRL/SRA, ROL with SHIFT_PIPE_ROTATE_EN)
// Stage 1 shifts by the shamt multiple of 4, stage 2 by shamt[1:0].
module shift_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
`ifdef SHIFT_PIPE_ROTATE_EN
  localparam logic [1:0] MODE_ROL = 2'b11;
`endif

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [1:0]       s1_mode;
  logic [1:0]       s1_fine;
  logic             s1_sign;

  logic             s2_adv;
  logic             s1_adv;
  logic [SHW-1:0]   coarse_amt;
  logic [WIDTH-1:0] coarse;
  logic [WIDTH-1:0] fine;

  assign s2_adv     = !out_valid || out_ready;
  assign s1_adv     = !s1_valid || s2_adv;
  assign in_ready   = s1_adv;
  assign coarse_amt = {in_shamt[SHW-1:2], 2'b00};

  // Shifting by WIDTH yields zero, so a zero amount leaves the wrap term empty.
  always_comb begin
    coarse = in_data << coarse_amt;
    case (in_mode)
      MODE_SRL: coarse = in_data >> coarse_amt;
      MODE_SRA: coarse = $signed(in_data) >>> coarse_amt;
`ifdef SHIFT_PIPE_ROTATE_EN
      MODE_ROL: coarse = (in_data << coarse_amt) | (in_data >> (WIDTH - int'(coarse_amt)));
`endif
      default: ;
    endcase
  end

  always_comb begin
    fine = s1_data << s1_fine;
    case (s1_mode)
      MODE_SRL: fine = s1_data >> s1_fine;
      MODE_SRA: fine = (s1_data >> s1_fine) | ({WIDTH{s1_sign}} << (WIDTH - int'(s1_fine)));
`ifdef SHIFT_PIPE_ROTATE_EN
      MODE_ROL: fine = (s1_data << s1_fine) | (s1_data >> (WIDTH - int'(s1_fine)));
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= 2'b00;
      s1_fine  <= 2'b00;
      s1_sign  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= coarse;
        s1_mode <= in_mode;
        s1_fine <= in_shamt[1:0];
        s1_sign <= in_data[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= fine;
      end
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - directed and random checks of shift_pipe at WIDTH 32, 8 and 64
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;

  logic        sw_valid, sw_ready;
  logic [7:0]  d8, o8;
  logic [2:0]  sh8;
  logic [1:0]  m8;
  logic        rdy8, ov8;
  logic [63:0] d64, o64;
  logic [5:0]  sh64;
  logic [1:0]  m64;
  logic        rdy64, ov64;

  int errors = 0;
  int checks = 0;
  logic [63:0] q8[$];
  logic [63:0] q64[$];

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  shift_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy8),
    .in_data(d8), .in_shamt(sh8), .in_mode(m8),
    .out_valid(ov8), .out_ready(sw_ready), .out_data(o8)
  );

  shift_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy64),
    .in_data(d64), .in_shamt(sh64), .in_mode(m64),
    .out_valid(ov64), .out_ready(sw_ready), .out_data(o64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit reference, independent of the shifter structure.
  function automatic logic [63:0] ref_shift(input logic [63:0] d, input int w, input int sh,
                                            input logic [1:0] m);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      case (m)
        2'b00: r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        2'b01: r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
        2'b10: r[i] = (i + sh < w) ? d[i+sh] : d[w-1];
        default: begin
`ifdef SHIFT_PIPE_ROTATE_EN
          r[i] = d[(i - sh + w) % w];
`else
          r[i] = (i >= sh) ? d[i-sh] : 1'b0;
`endif
        end
      endcase
    end
    return r;
  endfunction

  // Called at posedge+1; presents one operand and checks the two-cycle latency.
  task automatic run1(input logic [31:0] d, input int sh, input logic [1:0] m,
                      input logic [31:0] exp, input string tag);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_shamt  = sh[4:0];
    in_mode   = m;
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    check({tag, "_early"}, out_valid, 0);
    @(posedge clk); #1;
    check({tag, "_valid"}, out_valid, 1);
    check(tag, out_data, exp);
  endtask

  task automatic sw_cycle(input bit v, input bit r);
    logic [63:0] e;
    @(posedge clk); #1;
    sw_valid = v;
    sw_ready = r;
    d8   = 8'($urandom);
    sh8  = 3'($urandom_range(0, 7));
    m8   = 2'($urandom_range(0, 3));
    d64  = {$urandom, $urandom};
    sh64 = 6'($urandom_range(0, 63));
    m64  = 2'($urandom_range(0, 3));
    #1;
    if (sw_valid && rdy8)  q8.push_back(ref_shift({56'b0, d8}, 8, int'(sh8), m8));
    if (sw_valid && rdy64) q64.push_back(ref_shift(d64, 64, int'(sh64), m64));
    if (ov8 && sw_ready) begin
      if (q8.size() == 0) check("sw8_extra", 1, 0);
      else begin
        e = q8.pop_front();
        check("sw8_data", {56'b0, o8}, e);
      end
    end
    if (ov64 && sw_ready) begin
      if (q64.size() == 0) check("sw64_extra", 1, 0);
      else begin
        e = q64.pop_front();
        check("sw64_data", o64, e);
      end
    end
  endtask

  initial begin
    int acc;
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_shamt = '0; in_mode = '0;
    sw_valid = 1'b0; sw_ready = 1'b0;
    d8 = '0; sh8 = '0; m8 = '0; d64 = '0; sh64 = '0; m64 = '0;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run1(32'h0000_0001, 2,  2'b00, 32'h0000_0004, "sll2");
    run1(32'h0000_0001, 31, 2'b00, 32'h8000_0000, "sll31");
    run1(32'h8000_00F0, 4,  2'b10, 32'hF800_000F, "sra4");
    run1(32'h8000_00F0, 4,  2'b01, 32'h0800_000F, "srl4");
    run1(32'h8000_00F0, 0,  2'b10, 32'h8000_00F0, "sra0");
    run1(32'h8000_00F0, 0,  2'b01, 32'h8000_00F0, "srl0");
    run1(32'h8000_00F0, 7,  2'b10, 32'hFF00_0001, "sra7");
`ifdef SHIFT_PIPE_ROTATE_EN
    run1(32'h8000_0001, 1,  2'b11, 32'h0000_0003, "rol1");
`else
    run1(32'h8000_0001, 1,  2'b11, 32'h0000_0002, "rol1");
`endif

    // Backpressure: three SLL-by-1 operands against a stalled consumer.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_shamt = 5'd1; in_mode = 2'b00; in_data = 32'd1;
    #1; check("bp_acc1", in_ready, 1);
    @(posedge clk); #1;
    in_data = 32'd2;
    #1; check("bp_acc2", in_ready, 1);
    @(posedge clk); #1;
    in_data = 32'd3;
    #1;
    check("bp_full", in_ready, 0);
    check("bp_hold0", out_data, 2);
    repeat (3) @(posedge clk);
    #2;
    check("bp_hold", out_data, 2);
    check("bp_still_full", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_release", in_ready, 1);
    check("bp_out0_valid", out_valid, 1);
    check("bp_out0", out_data, 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #1;
    check("bp_out1_valid", out_valid, 1);
    check("bp_out1", out_data, 4);
    @(posedge clk); #2;
    check("bp_out2_valid", out_valid, 1);
    check("bp_out2", out_data, 6);
    @(posedge clk); #2;
    check("bp_drained", out_valid, 0);

    // Reset with two operations in flight.
    out_ready = 1'b0; in_valid = 1'b1; in_shamt = 5'd0; in_data = 32'd5;
    @(posedge clk); #1;
    in_data = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_pre_valid", out_valid, 1);
    #1; rst_n = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_data", out_data, 0);
    check("rst_mid_ready", in_ready, 1);
    #1; rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_stale", out_valid, 0);
    end

    // Random sweep at WIDTH 8 and 64.
    acc = 0;
    cyc = 0;
    while (acc < 100 && cyc < 3000) begin
      sw_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      if (sw_valid && rdy8) acc++;
      cyc++;
    end
    check("sw_accepted", acc, 100);
    for (int i = 0; i < 6; i++) sw_cycle(1'b0, 1'b1);
    check("sw8_left", q8.size(), 0);
    check("sw64_left", q64.size(), 0);

    for (int i = 0; i < 30; i++) begin
      sw_cycle(1'b1, 1'b1);
      check("stream_ready8", rdy8, 1);
      if (i >= 2) begin
        check("stream_valid8", ov8, 1);
        check("stream_valid64", ov64, 1);
      end
    end
    for (int i = 0; i < 6; i++) sw_cycle(1'b0, 1'b1);
    check("stream8_left", q8.size(), 0);
    check("stream64_left", q64.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
